// File: rtl/sid_pkg.sv
// Shared SID voice constants: widths, LFSR seed/taps, control-register bit indices.
package sid_pkg;

  localparam int unsigned ACC_W  = 24;
  localparam int unsigned FREQ_W = 16;
  localparam int unsigned LFSR_W = 23;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFF8;
  localparam int unsigned LFSR_FB_A = 22;
  localparam int unsigned LFSR_FB_B = 17;

  // MSB-first order of the LFSR bits that form the 8-bit noise sample
  localparam int unsigned NOISE_TAP [8] = '{20, 18, 14, 11, 9, 5, 2, 0};

  localparam int unsigned CTRL_TEST    = 3;
  localparam int unsigned CTRL_SYNC    = 1;
  localparam int unsigned CTRL_WAVE_LO = 4;
  localparam int unsigned CTRL_WAVE_HI = 7;

  function automatic logic [11:0] noise_taps(input logic [LFSR_W-1:0] l);
    logic [7:0] s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) s[7-i] = l[NOISE_TAP[i]];
    return {s, 4'b0000};
  endfunction

endpackage

// File: rtl/sid_noise_lfsr.sv
// 23-bit noise shift register with seed load, step enable and noise tap extraction.
module sid_noise_lfsr
  import sid_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic              step,
  output logic [11:0]       noise
);

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (seed_load) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_FB_A] ^ lfsr[LFSR_FB_B]};
    end
  end

  assign noise = noise_taps(lfsr);

endmodule

// File: rtl/sid_oscillator.sv
// SID voice phase accumulator with hard sync, MSB-rise pulse and noise LFSR clocking.
// Optional SID_OSC_PHASE_LOAD_EN adds phaseLoad/phaseVal for direct accumulator load.
module sid_oscillator
  import sid_pkg::*;
#(
  parameter int unsigned NOISE_CLK_BIT = 19
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [FREQ_W-1:0] freq,
  input  logic [7:0]        control,
  input  logic              syncIn,
`ifdef SID_OSC_PHASE_LOAD_EN
  input  logic              phaseLoad,
  input  logic [ACC_W-1:0]  phaseVal,
`endif
  output logic [ACC_W-1:0]  accOut,
  output logic [11:0]       noiseOut,
  output logic              msbRise
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] load_val;
  logic             load;
  logic             sync_pending;
  logic             test;
  logic             sync_mode;
  logic             sync_hit;
  logic             add_tick;
  logic             lfsr_step;
  logic             seed_load;
  logic             unused_ctrl;

  assign unused_ctrl = ^{control[7:4], control[2], control[0]};

`ifdef SID_OSC_PHASE_LOAD_EN
  assign load     = phaseLoad;
  assign load_val = phaseVal;
`else
  assign load     = 1'b0;
  assign load_val = '0;
`endif

  assign test      = control[CTRL_TEST];
  assign sync_mode = control[CTRL_SYNC];
  // A sync pulse arriving in the same cycle as the tick applies to that tick
  assign sync_hit  = sync_mode & (sync_pending | syncIn);
  assign sum       = acc + ACC_W'(freq);
  assign add_tick  = en & ~load & ~test & ~sync_hit;
  assign lfsr_step = add_tick & ~acc[NOISE_CLK_BIT] & sum[NOISE_CLK_BIT];
  assign seed_load = en & test;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      sync_pending <= 1'b0;
      msbRise      <= 1'b0;
    end else begin
      msbRise <= add_tick & ~acc[ACC_W-1] & sum[ACC_W-1];
      if (en) begin
        sync_pending <= 1'b0;
      end else if (syncIn && sync_mode) begin
        sync_pending <= 1'b1;
      end
      if (load) begin
        acc <= load_val;
      end else if (en) begin
        acc <= (test || sync_hit) ? '0 : sum;
      end
    end
  end

  assign accOut = acc;

  sid_noise_lfsr u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .step      (lfsr_step),
    .noise     (noiseOut)
  );

endmodule

// File: tb/tb_sid_oscillator.sv
// Directed table-driven bench for sid_oscillator plus hand sequences for sync, hold and reset.
module tb_sid_oscillator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] freq = '0;
  logic [7:0]  control = '0;
  logic        syncIn = 1'b0;
`ifdef SID_OSC_PHASE_LOAD_EN
  logic        phaseLoad = 1'b0;
  logic [23:0] phaseVal = '0;
`endif
  logic [23:0] accOut;
  logic [11:0] noiseOut;
  logic        msbRise;

  int unsigned checks = 0;
  int unsigned errors = 0;

  sid_oscillator #(.NOISE_CLK_BIT(19)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .freq     (freq),
    .control  (control),
    .syncIn   (syncIn),
`ifdef SID_OSC_PHASE_LOAD_EN
    .phaseLoad(phaseLoad),
    .phaseVal (phaseVal),
`endif
    .accOut   (accOut),
    .noiseOut (noiseOut),
    .msbRise  (msbRise)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] freq;
    logic [7:0]  ctrl;
    int unsigned ticks;
    logic [23:0] acc;
    logic        msb;
    logic        chk_noise;
    logic [11:0] noise;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    en = 1'b0;
    syncIn = 1'b0;
    #2 rst = 1'b0;
  endtask

  task automatic tick_n(input int unsigned n);
    @(posedge clk);
    #1 en = 1'b1;
    repeat (n) @(posedge clk);
    #1 en = 1'b0;
  endtask

  // one tick on every 4th cycle
  task automatic gap_tick();
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0001, 8'h00, 4,   24'h000004, 1'b0, 1'b1, 12'hFC0};
    vecs[1] = '{16'hFFFF, 8'h00, 128, 24'h7FFF80, 1'b0, 1'b0, 12'h000};
    vecs[2] = '{16'hFFFF, 8'h00, 129, 24'h80FF7F, 1'b1, 1'b0, 12'h000};
    vecs[3] = '{16'hFFFF, 8'h00, 256, 24'hFFFF00, 1'b0, 1'b0, 12'h000};
    vecs[4] = '{16'hFFFF, 8'h00, 257, 24'h00FEFF, 1'b0, 1'b0, 12'h000};
    vecs[5] = '{16'h8000, 8'h00, 16,  24'h080000, 1'b0, 1'b1, 12'hFC0};
    vecs[6] = '{16'h8000, 8'h00, 80,  24'h280000, 1'b0, 1'b1, 12'hF80};
    vecs[7] = '{16'h0100, 8'h08, 5,   24'h000000, 1'b0, 1'b1, 12'hFC0};
    vecs[8] = '{16'h0100, 8'h02, 10,  24'h000A00, 1'b0, 1'b1, 12'hFC0};
    vecs[9] = '{16'h1234, 8'hF5, 3,   24'h00369C, 1'b0, 1'b1, 12'hFC0};

    do_reset();
    #1;
    chk("reset_acc", 32'(accOut), 32'h0);
    chk("reset_noise", 32'(noiseOut), 32'hFC0);
    chk("reset_msb", 32'(msbRise), 32'h0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      freq = vecs[i].freq;
      control = vecs[i].ctrl;
      tick_n(vecs[i].ticks);
      chk($sformatf("vec%0d_acc", i), 32'(accOut), 32'(vecs[i].acc));
      chk($sformatf("vec%0d_msb", i), 32'(msbRise), 32'(vecs[i].msb));
      if (vecs[i].chk_noise) chk($sformatf("vec%0d_noise", i), 32'(noiseOut), 32'(vecs[i].noise));
    end

    // msbRise lasts exactly one cycle after tick 129
    do_reset();
    control = 8'h00;
    freq = 16'hFFFF;
    tick_n(128);
    chk("msb_tick128", 32'(msbRise), 32'h0);
    tick_n(1);
    chk("msb_tick129", 32'(msbRise), 32'h1);
    @(posedge clk);
    #1 chk("msb_drop", 32'(msbRise), 32'h0);

    // LFSR step at bit-19 rise, then test mode re-seeds
    do_reset();
    freq = 16'h8000;
    tick_n(16);
    chk("lfsr_step16", 32'(dut.u_lfsr.lfsr), 32'h7FFFF0);
    chk("noise_step16", 32'(noiseOut), 32'hFC0);
    control = 8'h08;
    tick_n(2);
    chk("test_acc", 32'(accOut), 32'h0);
    chk("test_lfsr", 32'(dut.u_lfsr.lfsr), 32'h7FFFF8);
    chk("test_msb", 32'(msbRise), 32'h0);
    control = 8'h00;

    // hard sync with sparse ticks
    do_reset();
    control = 8'h02;
    freq = 16'h0100;
    repeat (3) gap_tick();
    chk("sync_pre", 32'(accOut), 32'h300);
    @(posedge clk);
    #1 syncIn = 1'b1;
    @(posedge clk);
    #1 syncIn = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    chk("sync_pending_zero", 32'(accOut), 32'h0);
    gap_tick();
    gap_tick();
    chk("sync_cleared", 32'(accOut), 32'h200);
    @(posedge clk);
    #1 syncIn = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1 syncIn = 1'b0;
    en = 1'b0;
    chk("sync_coincident", 32'(accOut), 32'h0);
    gap_tick();
    chk("sync_after_coinc", 32'(accOut), 32'h100);
    control = 8'h00;
    @(posedge clk);
    #1 syncIn = 1'b1;
    @(posedge clk);
    #1 syncIn = 1'b0;
    control = 8'h02;
    gap_tick();
    chk("sync_not_latched", 32'(accOut), 32'h200);
    control = 8'h00;
    @(posedge clk);
    #1 syncIn = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1 syncIn = 1'b0;
    en = 1'b0;
    chk("sync_disabled", 32'(accOut), 32'h300);

    // hold with en low while freq changes, then async reset
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 freq = 16'(c * 16'h1111);
    end
    #1 chk("hold_acc", 32'(accOut), 32'h300);
    freq = 16'h8000;
    tick_n(48);
    chk("pre_rst_acc", 32'(accOut), 32'h180300);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_acc", 32'(accOut), 32'h0);
    chk("async_rst_noise", 32'(noiseOut), 32'hFC0);
    #2 rst = 1'b0;
    freq = 16'h0001;
    tick_n(1);
    chk("post_rst_tick", 32'(accOut), 32'h1);

`ifdef SID_OSC_PHASE_LOAD_EN
    do_reset();
    @(posedge clk);
    #1 phaseLoad = 1'b1;
    phaseVal = 24'h7FFFFF;
    @(posedge clk);
    #1 phaseLoad = 1'b0;
    chk("pl_load", 32'(accOut), 32'h7FFFFF);
    chk("pl_no_msb", 32'(msbRise), 32'h0);
    freq = 16'h0001;
    tick_n(1);
    chk("pl_tick_acc", 32'(accOut), 32'h800000);
    chk("pl_tick_msb", 32'(msbRise), 32'h1);
    @(posedge clk);
    #1 phaseLoad = 1'b1;
    phaseVal = 24'h000123;
    en = 1'b1;
    @(posedge clk);
    #1 phaseLoad = 1'b0;
    en = 1'b0;
    chk("pl_beats_en", 32'(accOut), 32'h123);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
